// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, bus widths and the responder's
// data-phase state encoding.
package ahb_pkg;

  localparam int AHB_ADDRESS_WIDTH = 32;
  localparam int AHB_DATA_WIDTH    = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slv_state_t;

  // NONSEQ and SEQ are the only transfer types that carry a data phase.
  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == NONSEQ) || (htrans == SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// DEPTH x DW word store with a byte-enable write port, combinational read port
// and synchronous clear.
module ahb_slave_mem #(
  parameter int DW    = 64,
  parameter int DEPTH = 256,
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LANES = DW / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [LANES-1:0] wbe,
  input  logic [DW-1:0]    wdata,
  input  logic [IW-1:0]    raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Clear on reset; otherwise commit the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < LANES; b++) begin
        if (wbe[b]) begin
          mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory responder: legality check, byte-lane decode, wait-state and
// two-cycle ERROR sequencing around an ahb_slave_mem word store.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int AW          = AHB_ADDRESS_WIDTH,
  parameter int DW          = AHB_DATA_WIDTH,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [DW-1:0] HRDATA
);

  localparam int              LANES     = DW / 8;
  localparam int              IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   MEM_BYTES = AW'(DEPTH * LANES);
  localparam logic [31:0]     LANES_U   = 32'(LANES);
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);

  slv_state_t       state_r;
  logic [3:0]       cnt_r;
  logic             write_r;
  logic [IW-1:0]    idx_r;
  logic [LANES-1:0] be_r;
  logic             hreadyout_r;
  logic             hresp_r;

  logic             accept_s;
  logic             legal_s;
  logic [31:0]      size_bytes_s;
  logic [31:0]      lower_s;
  logic [LANES-1:0] be_s;
  logic [IW-1:0]    idx_s;
  logic             we_s;
  logic [DW-1:0]    rdata_s;

  assign accept_s = HSEL && HREADY && is_active_trans(HTRANS);

  // Address-phase decode: legality, enabled byte lanes and word index.
  always_comb begin
    size_bytes_s = 32'd1 << HSIZE;
    lower_s      = 32'(HADDR % AW'(LANES));
    legal_s      = (HADDR < MEM_BYTES) && (size_bytes_s <= LANES_U) &&
                   ((HADDR & AW'(size_bytes_s - 32'd1)) == '0);
    idx_s        = IW'(HADDR / AW'(LANES));
    be_s         = '0;
    for (int i = 0; i < LANES; i++) begin
      be_s[i] = (32'(i) >= lower_s) && (32'(i) < lower_s + size_bytes_s);
    end
  end

  // Data-phase FSM; HREADYOUT/HRESP are registered alongside the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      write_r     <= 1'b0;
      idx_r       <= '0;
      be_r        <= '0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DATA, S_ERR2: begin
          if (accept_s) begin
            write_r <= HWRITE;
            idx_r   <= idx_s;
            be_r    <= be_s;
            if (!legal_s) begin
              state_r     <= S_ERR1;
              cnt_r       <= 4'd0;
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b1;
            end else if (WAIT_CYCLES > 0) begin
              state_r     <= S_WAIT;
              cnt_r       <= WAIT_INIT;
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b0;
            end else begin
              state_r     <= S_DATA;
              cnt_r       <= 4'd0;
              hreadyout_r <= 1'b1;
              hresp_r     <= 1'b0;
            end
          end else begin
            state_r     <= S_IDLE;
            cnt_r       <= 4'd0;
            write_r     <= 1'b0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt_r == 4'd1) begin
            state_r     <= S_DATA;
            cnt_r       <= 4'd0;
            hreadyout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_ERR1: begin
          state_r     <= S_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b1;
        end
        default: begin
          state_r     <= S_IDLE;
          cnt_r       <= 4'd0;
          write_r     <= 1'b0;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b0;
        end
      endcase
    end
  end

  // Writes commit on the edge that ends an OKAY data phase, so a read accepted
  // on that same edge already sees the new word.
  assign we_s = (state_r == S_DATA) && write_r;

  ahb_slave_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .waddr (idx_r),
    .wbe   (be_r),
    .wdata (HWDATA),
    .raddr (idx_r),
    .rdata (rdata_s)
  );

  // Read data is only driven in the completing cycle of a read data phase.
  always_comb begin
    if ((state_r == S_DATA) && !write_r) begin
      HRDATA = rdata_s;
    end else begin
      HRDATA = '0;
    end
  end

  assign HREADYOUT = hreadyout_r;
  assign HRESP     = hresp_r;

endmodule
